mips_bus_port_arbiter: RTL and testbench

MIPS_BUS_PORT_ARBITER -- requirements
Module: mips_bus_port_arbiter

---
 rtl/mips_bus_pkg.sv | 41 ++++
 rtl/mips_bus_load_align.sv | 42 ++++
 rtl/mips_bus_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mips_bus_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS bus port arbiter: access sizes,
// FSM states, byte-lane masks and the alignment rule.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RDATA,
    ST_RESP
  } state_e;

  localparam int MAX_CH = 4;

  function automatic logic [7:0] be_mask(input size_e sz);
    case (sz)
      SZ_BYTE: return 8'h01;
      SZ_HALF: return 8'h03;
      SZ_WORD: return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // A dword on a 32-bit bus cannot be issued, so it is reported like a misalignment.
  function automatic logic is_misaligned(input size_e sz, input logic [2:0] lo,
                                         input logic dword_ok);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo[1:0];
      default: return !dword_ok || (|lo);
    endcase
  endfunction

endpackage

// File: rtl/mips_bus_load_align.sv
// Load data aligner: shifts the bus word down by the byte offset, then
// zero- or sign-extends it according to the access size.
module mips_bus_load_align
  import mips_bus_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_keep;
  logic              w_sign;

  always_comb begin
    w_shifted = i_rdata >> {i_offset, 3'b000};
    w_keep    = '1;
    w_sign    = 1'b0;
    case (size_e'(i_size))
      SZ_BYTE: begin
        w_keep = DATA_W'(8'hFF);
        w_sign = w_shifted[7];
      end
      SZ_HALF: begin
        w_keep = DATA_W'(16'hFFFF);
        w_sign = w_shifted[15];
      end
      SZ_WORD: begin
        w_keep = DATA_W'(32'hFFFF_FFFF);
        w_sign = w_shifted[31];
      end
      default: ;
    endcase
    o_data = (w_shifted & w_keep) | ((i_signed && w_sign) ? ~w_keep : '0);
  end

endmodule

// File: rtl/mips_bus_port_arbiter.sv
// Round-robin arbiter that funnels per-channel load/store requests onto a
// single Avalon master port, one transaction outstanding at a time.
module mips_bus_port_arbiter
  import mips_bus_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [2*NUM_CH-1:0]      req_size,
  input  logic [NUM_CH-1:0]        req_signed,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [DATA_W*NUM_CH-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     resp_misalign,
  output logic [ADDR_W-1:0]        address,
  output logic                     write,
  output logic                     read,
  output logic [DATA_W-1:0]        writedata,
  output logic [DATA_W/8-1:0]      byteenable,
  input  logic                     waitrequest,
  input  logic [DATA_W-1:0]        readdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  state_e              r_state;
  state_e              w_state_next;
  logic [1:0]          r_rr_ptr;
  logic [1:0]          r_ch;
  logic                r_write;
  size_e               r_size;
  logic                r_signed;
  logic [OFF_W-1:0]    r_offset;
  logic                r_misalign;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_wdata;
  logic [BYTES-1:0]    r_be;
  logic [DATA_W-1:0]   r_rdata;

  // Request vectors widened to MAX_CH so any channel count indexes cleanly.
  logic [MAX_CH-1:0]        w_valid_pad;
  logic [MAX_CH-1:0]        w_write_pad;
  logic [MAX_CH-1:0]        w_signed_pad;
  logic [2*MAX_CH-1:0]      w_size_pad;
  logic [ADDR_W*MAX_CH-1:0] w_addr_pad;
  logic [DATA_W*MAX_CH-1:0] w_wdata_pad;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_valid_pad  = '0;
    w_write_pad  = '0;
    w_signed_pad = '0;
    w_size_pad   = '0;
    w_addr_pad   = '0;
    w_wdata_pad  = '0;
    w_valid_pad[NUM_CH-1:0]         = req_valid;
    w_write_pad[NUM_CH-1:0]         = req_write;
    w_signed_pad[NUM_CH-1:0]        = req_signed;
    w_size_pad[2*NUM_CH-1:0]        = req_size;
    w_addr_pad[ADDR_W*NUM_CH-1:0]   = req_addr;
    w_wdata_pad[DATA_W*NUM_CH-1:0]  = req_wdata;
  end

  logic       w_gnt_found;
  logic [1:0] w_gnt_idx;
  logic [2:0] w_scan;

  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_scan = 3'(r_rr_ptr) + 3'(k);
      if (w_scan >= 3'(NUM_CH)) w_scan = w_scan - 3'(NUM_CH);
      if (!w_gnt_found && w_valid_pad[w_scan[1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan[1:0];
      end
    end
  end

  logic              w_sel_write;
  logic              w_sel_signed;
  size_e             w_sel_size;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [OFF_W-1:0]  w_sel_offset;
  logic              w_sel_misalign;
  logic [BYTES-1:0]  w_sel_be;
  logic [2:0]        w_ptr_inc;
  logic [1:0]        w_ptr_next;

  assign w_sel_write    = w_write_pad[w_gnt_idx];
  assign w_sel_signed   = w_signed_pad[w_gnt_idx];
  assign w_sel_size     = size_e'(w_size_pad[{w_gnt_idx, 1'b0} +: 2]);
  assign w_sel_addr     = w_addr_pad[w_gnt_idx*ADDR_W +: ADDR_W];
  assign w_sel_wdata    = w_wdata_pad[w_gnt_idx*DATA_W +: DATA_W];
  assign w_sel_offset   = w_sel_addr[OFF_W-1:0];
  assign w_sel_misalign = is_misaligned(w_sel_size, w_sel_addr[2:0], DATA_W == 64);
  assign w_sel_be       = BYTES'(be_mask(w_sel_size)) << w_sel_offset;
  assign w_ptr_inc      = 3'(w_gnt_idx) + 3'd1;
  assign w_ptr_next     = (w_ptr_inc == 3'(NUM_CH)) ? 2'd0 : w_ptr_inc[1:0];

  logic w_grant;

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_found && !reset) begin
          w_grant      = 1'b1;
          w_state_next = w_sel_misalign ? ST_RESP : ST_CMD;
        end
      end
      ST_CMD:   if (!waitrequest) w_state_next = r_write ? ST_RESP : ST_RDATA;
      ST_RDATA: w_state_next = ST_RESP;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  logic [DATA_W-1:0] w_load_data;

  mips_bus_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .i_rdata  (readdata),
    .i_offset (r_offset),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_ch       <= '0;
      r_write    <= 1'b0;
      r_size     <= SZ_BYTE;
      r_signed   <= 1'b0;
      r_offset   <= '0;
      r_misalign <= 1'b0;
      r_address  <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_rr_ptr   <= w_ptr_next;
        r_ch       <= w_gnt_idx;
        r_write    <= w_sel_write;
        r_size     <= w_sel_size;
        r_signed   <= w_sel_signed;
        r_offset   <= w_sel_offset;
        r_misalign <= w_sel_misalign;
        r_address  <= w_sel_addr & ~ADDR_W'(BYTES - 1);
        r_wdata    <= w_sel_wdata << {w_sel_offset, 3'b000};
        r_be       <= w_sel_be;
        r_rdata    <= '0;
      end
      if (r_state == ST_RDATA) r_rdata <= w_load_data;
    end
  end

  logic [MAX_CH-1:0] w_ready_pad;
  logic [MAX_CH-1:0] w_resp_pad;

  always_comb begin
    w_ready_pad = '0;
    w_resp_pad  = '0;
    if (w_grant) w_ready_pad[w_gnt_idx] = 1'b1;
    if (r_state == ST_RESP) w_resp_pad[r_ch] = 1'b1;
  end

  assign req_ready     = w_ready_pad[NUM_CH-1:0];
  assign resp_valid    = w_resp_pad[NUM_CH-1:0];
  assign resp_misalign = (r_state == ST_RESP) && r_misalign;
  assign resp_rdata    = r_rdata;
  assign read          = (r_state == ST_CMD) && !r_write;
  assign write         = (r_state == ST_CMD) && r_write;
  assign address       = r_address;
  assign writedata     = r_wdata;
  assign byteenable    = r_be;

endmodule

// File: tb/tb_mips_bus_port_arbiter.sv
// Directed bench for mips_bus_port_arbiter: a 2-channel 32-bit instance and a
// 1-channel 64-bit instance driven by hand-computed vectors.
module tb_mips_bus_port_arbiter;

  logic        clk;
  logic        reset;

  logic [1:0]  req_valid, req_write, req_signed;
  logic [3:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic [31:0] address;
  logic        write, read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [0:0]  req_valid_64, req_write_64, req_signed_64;
  logic [1:0]  req_size_64;
  logic [31:0] req_addr_64;
  logic [63:0] req_wdata_64;
  logic [0:0]  req_ready_64, resp_valid_64;
  logic [63:0] resp_rdata_64;
  logic        resp_misalign_64;
  logic [31:0] address_64;
  logic        write_64, read_64;
  logic [63:0] writedata_64;
  logic [7:0]  byteenable_64;
  logic        waitrequest_64;
  logic [63:0] readdata_64;

  int n_checks = 0;
  int n_errors = 0;

  mips_bus_port_arbiter #(.NUM_CH(2), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .address(address), .write(write), .read(read),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  mips_bus_port_arbiter #(.NUM_CH(1), .DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_64), .req_write(req_write_64), .req_size(req_size_64),
    .req_signed(req_signed_64), .req_addr(req_addr_64), .req_wdata(req_wdata_64),
    .req_ready(req_ready_64), .resp_valid(resp_valid_64), .resp_rdata(resp_rdata_64),
    .resp_misalign(resp_misalign_64), .address(address_64), .write(write_64),
    .read(read_64), .writedata(writedata_64), .byteenable(byteenable_64),
    .waitrequest(waitrequest_64), .readdata(readdata_64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] ad, input logic [31:0] wd);
    req_write[ch]         = wr;
    req_size[ch*2 +: 2]   = sz;
    req_signed[ch]        = sg;
    req_addr[ch*32 +: 32] = ad;
    req_wdata[ch*32 +: 32] = wd;
  endtask

  logic [1:0]  exp_gnt;
  logic [31:0] exp_rd;

  initial begin
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_signed = '0; req_size = '0;
    req_addr = '0; req_wdata = '0; waitrequest = 1'b0; readdata = '0;
    req_valid_64 = '0; req_write_64 = '0; req_signed_64 = '0; req_size_64 = '0;
    req_addr_64 = '0; req_wdata_64 = '0; waitrequest_64 = 1'b0; readdata_64 = '0;
    tick();
    tick();

    // Reset state
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_misalign", resp_misalign, 0);
    check("rst_address", address, 0);
    check("rst_writedata", writedata, 0);
    check("rst_byteenable", byteenable, 0);
    check("rst_rdata", resp_rdata, 0);

    // Both channels loading words: grants alternate 0,1,0,1 at 4 cycles each
    reset = 1'b0;
    set_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    set_req(1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_rd  = 32'hA000_0000 + 32'(i);
      #1;
      check("rr_ready", req_ready, exp_gnt);
      tick();
      check("rr_ready_pulse", req_ready, 0);
      check("rr_read", read, 1);
      check("rr_address", address, (exp_gnt == 2'b01) ? 32'h100 : 32'h200);
      check("rr_be", byteenable, 4'b1111);
      tick();
      readdata = exp_rd;
      check("rr_read_drop", read, 0);
      tick();
      check("rr_resp_valid", resp_valid, exp_gnt);
      check("rr_resp_no_ready", req_ready, 0);
      check("rr_rdata", resp_rdata, exp_rd);
      if (i == 3) req_valid = 2'b00;
      tick();
    end

    // ch1 signed byte at 0x1003; fields changed after grant must be ignored
    set_req(1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0);
    req_valid = 2'b10;
    #1;
    check("sb_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    set_req(1, 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0);
    #1;
    check("sb_address", address, 32'h1000);
    check("sb_be", byteenable, 4'b1000);
    check("sb_read", read, 1);
    check("sb_write", write, 0);
    tick();
    readdata = 32'h80AB_CDEF;
    tick();
    check("sb_resp_valid", resp_valid, 2'b10);
    check("sb_rdata", resp_rdata, 32'hFFFF_FF80);
    check("sb_misalign", resp_misalign, 0);
    tick();
    check("sb_resp_drop", resp_valid, 0);
    check("sb_idle_ready", req_ready, 0);

    // ch0 unsigned half at 0x0002
    set_req(0, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0);
    req_valid = 2'b01;
    #1;
    check("uh_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    check("uh_address", address, 32'h0);
    check("uh_be", byteenable, 4'b1100);
    tick();
    readdata = 32'h8765_4321;
    tick();
    check("uh_rdata", resp_rdata, 32'h0000_8765);
    tick();

    // ch0 store half 0xBEEF at 0x2002, waitrequest high for 3 cycles
    waitrequest = 1'b1;
    set_req(0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_BEEF);
    req_valid = 2'b01;
    #1;
    check("st_ready", req_ready, 2'b01);
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        req_valid = 2'b00;
        set_req(0, 1'b1, 2'b00, 1'b0, 32'h0000_5551, 32'h0000_0011);
      end
      if (c == 3) waitrequest = 1'b0;
      #1;
      check("st_write", write, 1);
      check("st_read", read, 0);
      check("st_address", address, 32'h2000);
      check("st_be", byteenable, 4'b1100);
      check("st_wdata", writedata, 32'hBEEF_0000);
      check("st_no_resp", resp_valid, 0);
      tick();
    end
    check("st_resp_valid", resp_valid, 2'b01);
    check("st_write_drop", write, 0);
    check("st_rdata_zero", resp_rdata, 0);
    tick();
    check("st_resp_drop", resp_valid, 0);

    // ch1 misaligned word at 0x0006: answered without a bus command
    set_req(1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    req_valid = 2'b10;
    #1;
    check("ma_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    #1;
    check("ma_resp_valid", resp_valid, 2'b10);
    check("ma_misalign", resp_misalign, 1);
    check("ma_read", read, 0);
    check("ma_write", write, 0);
    tick();
    check("ma_misalign_drop", resp_misalign, 0);
    check("ma_resp_drop", resp_valid, 0);
    check("ma_read_idle", read, 0);

    // Reset during a stalled read abandons it
    waitrequest = 1'b1;
    set_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
    req_valid = 2'b01;
    #1;
    check("rs_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    check("rs_read", read, 1);
    check("rs_address", address, 32'h3000);
    reset = 1'b1;
    tick();
    check("rs_read_drop", read, 0);
    check("rs_address_clr", address, 0);
    check("rs_no_resp", resp_valid, 0);
    reset = 1'b0;
    waitrequest = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rs_quiet_resp", resp_valid, 0);
      check("rs_quiet_read", read, 0);
    end
    set_req(0, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hCAFE_F00D);
    set_req(1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
    req_valid = 2'b11;
    #1;
    check("rs_regrant_ch0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    check("rs_wdata", writedata, 32'hCAFE_F00D);
    check("rs_write", write, 1);
    tick();
    check("rs_write_resp", resp_valid, 2'b01);
    tick();

    // 64-bit bus: dword at 0x08, then signed word at 0x0C
    req_size_64 = 2'b11; req_addr_64 = 32'h0000_0008; req_valid_64 = 1'b1;
    #1;
    check("dw_ready", req_ready_64, 1);
    tick();
    req_valid_64 = 1'b0;
    #1;
    check("dw_be", byteenable_64, 8'hFF);
    check("dw_address", address_64, 32'h8);
    check("dw_read", read_64, 1);
    tick();
    readdata_64 = 64'h0123_4567_89AB_CDEF;
    tick();
    check("dw_resp_valid", resp_valid_64, 1);
    check("dw_rdata", resp_rdata_64, 64'h0123_4567_89AB_CDEF);
    tick();

    req_size_64 = 2'b10; req_signed_64 = 1'b1; req_addr_64 = 32'h0000_000C;
    req_valid_64 = 1'b1;
    #1;
    check("sw64_ready", req_ready_64, 1);
    tick();
    req_valid_64 = 1'b0;
    #1;
    check("sw64_be", byteenable_64, 8'hF0);
    check("sw64_address", address_64, 32'h8);
    tick();
    readdata_64 = 64'h8000_0001_DEAD_BEEF;
    tick();
    check("sw64_rdata", resp_rdata_64, 64'hFFFF_FFFF_8000_0001);
    check("sw64_misalign", resp_misalign_64, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
